// File: rtl/drp_reconf_seq.sv
// drp_reconf_seq
//   Reprograms a PLL through its DRP port, one table entry at a time, using
//   read-modify-write. PLL_RST is held for the whole update, then released,
//   and the sequencer waits for LOCKED before reporting DONE.
//
//   Ports
//     DCLK, RSTN        DRP clock, asynchronous active-low reset
//     START             update request, honoured only while idle
//     BUSY/DONE/ERROR   status: busy level, success pulse, sticky failure
//     ENTRY_IDX         index into the external entry table
//     ENTRY_ADDR/MASK/DATA  table contents for ENTRY_IDX (combinational)
//     DADDR/DEN/DWE/DI  DRP request side
//     DO/DRDY           DRP response side
//     PLL_RST/LOCKED    PLL reset (active high) and lock indicator
module drp_reconf_seq #(
  parameter int N_ENTRIES    = 23,
  parameter int IDX_W        = 5,
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic             DCLK,
  input  logic             RSTN,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [IDX_W-1:0] ENTRY_IDX,
  input  logic [6:0]       ENTRY_ADDR,
  input  logic [15:0]      ENTRY_MASK,
  input  logic [15:0]      ENTRY_DATA,
  output logic [6:0]       DADDR,
  output logic             DEN,
  output logic             DWE,
  output logic [15:0]      DI,
  input  logic [15:0]      DO,
  input  logic             DRDY,
  output logic             PLL_RST,
  input  logic             LOCKED
);

  // One shared counter serves HOLD, both DRDY waits and the lock wait.
  localparam int MAX_A   = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RD,
    S_WAIT_R,
    S_WR,
    S_WAIT_W,
    S_REL,
    S_LOCK
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_q;
  logic             done_q;
  logic             err_q;
  logic             pll_rst_q;
  logic [6:0]       daddr_q;
  logic [15:0]      di_q;
  logic [15:0]      wdata_q;

  logic hold_end;
  logic drdy_to;
  logic lock_ok;
  logic lock_to;
  logic last_entry;

  function automatic logic [15:0] rmw_merge(input logic [15:0] rd,
                                            input logic [15:0] mask,
                                            input logic [15:0] data);
    // mask bit 1 keeps the current register bit, 0 takes the new one
    return (rd & mask) | (data & ~mask);
  endfunction

  assign hold_end   = (cnt == CNT_W'(RST_HOLD - 1));
  assign drdy_to    = (cnt == CNT_W'(DRDY_TIMEOUT - 1));
  // LOCKED is blanked for the first RST_HOLD cycles after release
  assign lock_ok    = (cnt >= CNT_W'(RST_HOLD)) && LOCKED;
  assign lock_to    = (cnt == CNT_W'(LOCK_TIMEOUT - 1));
  assign last_entry = (idx_q == LAST_IDX);

  always_ff @(posedge DCLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = S_HOLD;
      S_HOLD:   if (hold_end) state_nxt = S_RD;
      S_RD:     state_nxt = S_WAIT_R;
      S_WAIT_R: begin
        if (DRDY)         state_nxt = S_WR;
        else if (drdy_to) state_nxt = S_IDLE;
      end
      S_WR:     state_nxt = S_WAIT_W;
      S_WAIT_W: begin
        if (DRDY)         state_nxt = last_entry ? S_REL : S_RD;
        else if (drdy_to) state_nxt = S_IDLE;
      end
      S_REL:    state_nxt = S_LOCK;
      S_LOCK:   if (lock_ok || lock_to) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // The counter restarts on every state change, so each timed state
    // measures its own dwell time and never runs past its limit.
    cnt_nxt = '0;
    if (state_nxt == state &&
        (state == S_HOLD || state == S_WAIT_R ||
         state == S_WAIT_W || state == S_LOCK)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_comb begin
    BUSY      = (state != S_IDLE);
    DEN       = (state == S_RD) || (state == S_WR);
    DWE       = (state == S_WR);
    // Address and write data follow the table during a strobe and hold
    // their previous value otherwise.
    DADDR     = DEN ? ENTRY_ADDR : daddr_q;
    DI        = DWE ? wdata_q : di_q;
    DONE      = done_q;
    ERROR     = err_q;
    ENTRY_IDX = idx_q;
    PLL_RST   = pll_rst_q;
  end

  always_ff @(posedge DCLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt       <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      pll_rst_q <= 1'b0;
      daddr_q   <= '0;
      di_q      <= '0;
    end else begin
      cnt    <= cnt_nxt;
      done_q <= (state == S_LOCK) && lock_ok;
      if (DEN) daddr_q <= ENTRY_ADDR;
      if (DWE) di_q    <= wdata_q;
      case (state)
        S_IDLE: begin
          if (START) begin
            err_q     <= 1'b0;
            idx_q     <= '0;
            pll_rst_q <= 1'b1;
          end
        end
        S_WAIT_R: begin
          if (!DRDY && drdy_to) err_q <= 1'b1;
        end
        S_WAIT_W: begin
          if (DRDY) begin
            if (last_entry) pll_rst_q <= 1'b0;
            else            idx_q     <= idx_q + 1'b1;
          end else if (drdy_to) begin
            // PLL stays in reset: its registers are only partly written
            err_q <= 1'b1;
          end
        end
        S_LOCK: begin
          if (!lock_ok && lock_to) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Merged write word; always captured before the WR strobe that uses it.
  always_ff @(posedge DCLK) begin
    if (state == S_WAIT_R && DRDY) begin
      wdata_q <= rmw_merge(DO, ENTRY_MASK, ENTRY_DATA);
    end
  end

endmodule

// File: tb/tb_drp_reconf_seq.sv
module tb_drp_reconf_seq;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int RH = 4;
  localparam int DT = 64;
  localparam int LT = 4096;
  localparam int K  = 1;
  // START-to-DONE latency with LOCKED already high: 1 + RH + N*(2+2K) + 1 + (RH+1)
  localparam int LAT_FAST = 1 + RH + N * (2 + 2 * K) + 1 + (RH + 1);

  logic          DCLK;
  logic          RSTN;
  logic          START;
  logic          BUSY;
  logic          DONE;
  logic          ERROR;
  logic [IW-1:0] ENTRY_IDX;
  logic [6:0]    ENTRY_ADDR;
  logic [15:0]   ENTRY_MASK;
  logic [15:0]   ENTRY_DATA;
  logic [6:0]    DADDR;
  logic          DEN;
  logic          DWE;
  logic [15:0]   DI;
  logic [15:0]   DO;
  logic          DRDY;
  logic          PLL_RST;
  logic          LOCKED;

  logic [6:0]  tbl_addr [4];
  logic [15:0] tbl_mask [4];
  logic [15:0] tbl_data [4];
  logic [15:0] mem [128];

  logic        resp_drdy;
  logic        spur_drdy;
  int          rd_cnt;
  int          rd_base;
  int          rd_limit;

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  int total;
  int bad;

  assign ENTRY_ADDR = tbl_addr[ENTRY_IDX];
  assign ENTRY_MASK = tbl_mask[ENTRY_IDX];
  assign ENTRY_DATA = tbl_data[ENTRY_IDX];
  assign DRDY       = resp_drdy | spur_drdy;

  drp_reconf_seq #(
    .N_ENTRIES(N), .IDX_W(IW), .RST_HOLD(RH),
    .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)
  ) dut (
    .DCLK(DCLK), .RSTN(RSTN), .START(START), .BUSY(BUSY), .DONE(DONE),
    .ERROR(ERROR), .ENTRY_IDX(ENTRY_IDX), .ENTRY_ADDR(ENTRY_ADDR),
    .ENTRY_MASK(ENTRY_MASK), .ENTRY_DATA(ENTRY_DATA), .DADDR(DADDR),
    .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
    .PLL_RST(PLL_RST), .LOCKED(LOCKED)
  );

  initial begin
    DCLK = 1'b0;
    forever #5 DCLK = ~DCLK;
  end

  // DRP responder and scoreboard consumer: sees each strobe at the falling
  // edge, answers it K cycles later and checks it against the expected queue.
  initial begin
    int   pend;
    logic [15:0] pend_data;
    exp_t e;
    pend      = 0;
    pend_data = 16'h0;
    resp_drdy = 1'b0;
    DO        = 16'h0BAD;
    forever begin
      @(negedge DCLK);
      resp_drdy = 1'b0;
      DO        = 16'h0BAD;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          resp_drdy = 1'b1;
          DO        = pend_data;
        end
      end
      if (RSTN === 1'b1 && DEN === 1'b1) begin
        total++;
        if (PLL_RST !== 1'b1) begin
          bad++;
          $display("FAIL pll_rst_during_drp: got=%b want=1", PLL_RST);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_den: got we=%b addr=%h want no access", DWE, DADDR);
        end else begin
          e = exp_q.pop_front();
          if (DWE !== e.we || DADDR !== e.addr) begin
            bad++;
            $display("FAIL drp_access: got we=%b addr=%h want we=%b addr=%h", DWE, DADDR, e.we, e.addr);
          end
          if (e.we) begin
            total++;
            if (DI !== e.data) begin
              bad++;
              $display("FAIL drp_wdata: addr=%h got=%h want=%h", DADDR, DI, e.data);
            end
          end
        end
        if (DWE === 1'b1) begin
          mem[DADDR] = DI;
          pend = K;
        end else begin
          rd_cnt++;
          pend_data = mem[DADDR];
          if (rd_cnt - rd_base <= rd_limit) pend = K;
        end
      end
      if (DWE === 1'b1 && DEN !== 1'b1) begin
        total++;
        bad++;
        $display("FAIL dwe_without_den: got dwe=%b den=%b", DWE, DEN);
      end
    end
  end

  task automatic load_tables();
    tbl_addr[0] = 7'h08; tbl_mask[0] = 16'hFF00; tbl_data[0] = 16'h1234;
    tbl_addr[1] = 7'h09; tbl_mask[1] = 16'h0F0F; tbl_data[1] = 16'hBEEF;
    tbl_addr[2] = 7'h16; tbl_mask[2] = 16'h0000; tbl_data[2] = 16'hCAFE;
    tbl_addr[3] = 7'h7F; tbl_mask[3] = 16'hFFFF; tbl_data[3] = 16'h0000;
  endtask

  task automatic push_entry(input int i, input bit with_write);
    exp_t e;
    e.we   = 1'b0;
    e.addr = tbl_addr[i];
    e.data = 16'h0;
    exp_q.push_back(e);
    if (with_write) begin
      e.we   = 1'b1;
      e.data = (mem[tbl_addr[i]] & tbl_mask[i]) | (tbl_data[i] & ~tbl_mask[i]);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_all();
    for (int i = 0; i < N; i++) push_entry(i, 1'b1);
  endtask

  // Called at a falling edge; returns at the next one with START low again.
  task automatic pulse_start();
    START = 1'b1;
    @(negedge DCLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= limit; c++) begin
      if (DONE === 1'b1) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
      @(negedge DCLK);
    end
  endtask

  task automatic wait_idle(input int limit, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= limit; c++) begin
      if (BUSY === 1'b0) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
      @(negedge DCLK);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (3) @(negedge DCLK);
    total++;
    if ({BUSY, DONE, ERROR, DEN, DWE, PLL_RST} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got=%b want=000000", {BUSY, DONE, ERROR, DEN, DWE, PLL_RST});
    end
    total++;
    if (ENTRY_IDX !== 2'd0 || DADDR !== 7'h00 || DI !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data: got idx=%0d daddr=%h di=%h want 0 0 0", ENTRY_IDX, DADDR, DI);
    end
    RSTN = 1'b1;
    repeat (3) @(negedge DCLK);
    total++;
    if (BUSY !== 1'b0 || DEN !== 1'b0 || PLL_RST !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b den=%b rst=%b want 0 0 0", BUSY, DEN, PLL_RST);
    end
  endtask

  task automatic test_happy_path();
    int lat;
    bit seen;
    mem[7'h08] = 16'hA5A5;
    mem[7'h09] = 16'h1111;
    mem[7'h16] = 16'hFFFF;
    LOCKED = 1'b0;
    push_all();
    pulse_start();
    total++;
    if (BUSY !== 1'b1 || PLL_RST !== 1'b1) begin
      bad++;
      $display("FAIL happy_start: got busy=%b rst=%b want 1 1", BUSY, PLL_RST);
    end
    seen = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (PLL_RST === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge DCLK);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL happy_release: got no PLL_RST release within 100 cycles want release");
    end
    total++;
    if (exp_q.size() != 0 || ENTRY_IDX !== 2'd2) begin
      bad++;
      $display("FAIL happy_accesses: got pending=%0d idx=%0d want 0 2", exp_q.size(), ENTRY_IDX);
    end
    repeat (10) @(negedge DCLK);
    total++;
    if (DONE !== 1'b0 || BUSY !== 1'b1) begin
      bad++;
      $display("FAIL happy_lock_wait: got done=%b busy=%b want 0 1", DONE, BUSY);
    end
    LOCKED = 1'b1;
    wait_done(20, lat, seen);
    total++;
    if (!seen || lat != 2) begin
      bad++;
      $display("FAIL happy_done: got seen=%b lat=%0d want 1 2", seen, lat);
    end
    @(negedge DCLK);
    total++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || ERROR !== 1'b0 || PLL_RST !== 1'b0) begin
      bad++;
      $display("FAIL happy_end: got done=%b busy=%b err=%b rst=%b want 0 0 0 0", DONE, BUSY, ERROR, PLL_RST);
    end
    total++;
    if (mem[7'h08] !== 16'hA534) begin
      bad++;
      $display("FAIL rmw_result: got=%h want=a534", mem[7'h08]);
    end
  endtask

  task automatic test_lock_stuck_high();
    int lat;
    bit seen;
    LOCKED = 1'b1;
    push_all();
    pulse_start();
    wait_done(200, lat, seen);
    total++;
    if (!seen || lat != LAT_FAST) begin
      bad++;
      $display("FAIL lock_blanking: got seen=%b lat=%0d want 1 %0d", seen, lat, LAT_FAST);
    end
    @(negedge DCLK);
    total++;
    if (exp_q.size() != 0 || ERROR !== 1'b0) begin
      bad++;
      $display("FAIL lock_high_end: got pending=%0d err=%b want 0 0", exp_q.size(), ERROR);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    bit seen;
    LOCKED = 1'b1;
    push_all();
    pulse_start();
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 200; c++) begin
      if (DONE === 1'b1) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
      START = (c == 3 || c == 8 || c == 17);
      @(negedge DCLK);
    end
    START = 1'b0;
    total++;
    if (!seen || lat != LAT_FAST) begin
      bad++;
      $display("FAIL start_busy: got seen=%b lat=%0d want 1 %0d", seen, lat, LAT_FAST);
    end
    repeat (5) @(negedge DCLK);
    total++;
    if (BUSY !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL start_busy_end: got busy=%b pending=%0d want 0 0", BUSY, exp_q.size());
    end
  endtask

  task automatic test_spurious_drdy();
    int lat;
    bit seen;
    LOCKED    = 1'b1;
    spur_drdy = 1'b1;
    repeat (3) @(negedge DCLK);
    total++;
    if (BUSY !== 1'b0 || DEN !== 1'b0) begin
      bad++;
      $display("FAIL spur_idle: got busy=%b den=%b want 0 0", BUSY, DEN);
    end
    push_all();
    pulse_start();
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 1 + RH) spur_drdy = 1'b0;
      if (DONE === 1'b1) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
      @(negedge DCLK);
    end
    spur_drdy = 1'b0;
    total++;
    if (!seen || lat != LAT_FAST) begin
      bad++;
      $display("FAIL spur_hold: got seen=%b lat=%0d want 1 %0d", seen, lat, LAT_FAST);
    end
    @(negedge DCLK);
  endtask

  task automatic test_drdy_timeout();
    int lat;
    bit seen;
    LOCKED   = 1'b0;
    rd_base  = rd_cnt;
    rd_limit = 1;
    push_entry(0, 1'b1);
    push_entry(1, 1'b0);
    pulse_start();
    wait_idle(200, lat, seen);
    // entry 0 takes cycles 5..8, second read at 9, then DT wait cycles
    total++;
    if (!seen || lat != 1 + RH + (2 + 2 * K) + 1 + DT) begin
      bad++;
      $display("FAIL drdy_timeout_time: got seen=%b lat=%0d want 1 %0d", seen, lat, 1 + RH + (2 + 2 * K) + 1 + DT);
    end
    total++;
    if (ERROR !== 1'b1 || PLL_RST !== 1'b1 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL drdy_timeout_flags: got err=%b rst=%b done=%b want 1 1 0", ERROR, PLL_RST, DONE);
    end
    repeat (20) @(negedge DCLK);
    total++;
    if (ERROR !== 1'b1 || BUSY !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drdy_timeout_after: got err=%b busy=%b pending=%0d want 1 0 0", ERROR, BUSY, exp_q.size());
    end
    rd_limit = 1000;
  endtask

  task automatic test_lock_timeout();
    int lat;
    bit seen;
    LOCKED = 1'b0;
    push_all();
    pulse_start();
    total++;
    if (ERROR !== 1'b0 || BUSY !== 1'b1) begin
      bad++;
      $display("FAIL error_clear: got err=%b busy=%b want 0 1", ERROR, BUSY);
    end
    wait_idle(5000, lat, seen);
    total++;
    if (!seen || lat != 1 + RH + N * (2 + 2 * K) + 1 + LT) begin
      bad++;
      $display("FAIL lock_timeout_time: got seen=%b lat=%0d want 1 %0d", seen, lat, 1 + RH + N * (2 + 2 * K) + 1 + LT);
    end
    total++;
    if (ERROR !== 1'b1 || PLL_RST !== 1'b0 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL lock_timeout_flags: got err=%b rst=%b done=%b want 1 0 0", ERROR, PLL_RST, DONE);
    end
    @(negedge DCLK);
  endtask

  task automatic test_reset_mid_update();
    int lat;
    bit seen;
    LOCKED = 1'b0;
    push_all();
    pulse_start();
    seen = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (DEN === 1'b1 && DWE === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge DCLK);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL mid_write_seen: got no write strobe within 100 cycles want write");
    end
    @(negedge DCLK);
    #1 RSTN = 1'b0;
    #1;
    total++;
    if ({BUSY, DONE, ERROR, DEN, DWE, PLL_RST} !== 6'b0 || ENTRY_IDX !== 2'd0 ||
        DADDR !== 7'h00 || DI !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset: got flags=%b idx=%0d daddr=%h di=%h want all 0",
               {BUSY, DONE, ERROR, DEN, DWE, PLL_RST}, ENTRY_IDX, DADDR, DI);
    end
    exp_q.delete();
    repeat (2) @(negedge DCLK);
    RSTN   = 1'b1;
    LOCKED = 1'b1;
    @(negedge DCLK);
    push_all();
    pulse_start();
    wait_done(200, lat, seen);
    total++;
    if (!seen || lat != LAT_FAST || exp_q.size() != 0) begin
      bad++;
      $display("FAIL restart_after_reset: got seen=%b lat=%0d pending=%0d want 1 %0d 0",
               seen, lat, exp_q.size(), LAT_FAST);
    end
    @(negedge DCLK);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    RSTN      = 1'b0;
    START     = 1'b0;
    LOCKED    = 1'b0;
    spur_drdy = 1'b0;
    rd_cnt    = 0;
    rd_base   = 0;
    rd_limit  = 1000;
    for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i * 257);
    load_tables();
    @(negedge DCLK);
    test_reset();
    test_happy_path();
    test_lock_stuck_high();
    test_start_while_busy();
    test_spurious_drdy();
    test_drdy_timeout();
    test_lock_timeout();
    test_reset_mid_update();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
